capture_seq_ctrl: RTL and testbench
===================================

Name: capture_seq_ctrl

Overview:
- Frame-level sequencer for the crop/downsample/normalize path.
- Arms on a start command, clears the crop buffers at a frame boundary and gates pixel-valid into the crop block for one frame.
- Waits for the 784-pixel normalized image to complete, then presents it to the NN/SPART consumer with a valid/ack handshake.
- Supports single-shot and continuous capture, with a watchdog for stalled or incomplete frames.

Parameters:
- TIMEOUT_CYC, 2_000_000: cycles allowed from ARM entry to image completion before ERROR.
- CLR_CYC, 2: cycles oBufRst is held high in CLEAR (range 1..15).
- Y_LAST, 464: last camera row containing sampled pixels.
- FCNT_W, 16: frame counter width.

Ports:
- iCLK  in  1  clock
- iRST  in  1  reset, asynchronous, active-low
- iStart  in  1  single-cycle capture request
- iContinuous  in  1  level; re-arm automatically after each ack
- iFrameStart  in  1  single-cycle pulse at camera row 0, column 0
- iDVAL  in  1  camera pixel valid
- iY  in  10  current camera row
- iCropDone  in  1  single-cycle pulse from the normalizer: all 784 pixels written
- iImgAck  in  1  consumer has taken the image
- oBufRst  out  1  synchronous clear to the crop/normalize buffers
- oCapEn  out  1  gate; crop block uses (iDVAL && oCapEn)
- oImgValid  out  1  normalized image buffer is stable and valid
- oBusy  out  1  state is not IDLE and not ERROR
- oTimeout  out  1  sticky error flag
- oFrameCnt  out  FCNT_W  count of acknowledged images
- oState  out  3  encoded state, for debug/SPART status

Behaviour:
- Reset (iRST low, asynchronous): state IDLE; all outputs 0; watchdog and clear counters 0.
- All outputs are registered. An output change is visible the cycle after the causing input is sampled.
- State encoding: IDLE=0, ARM=1, CLEAR=2, CAPTURE=3, NORM_WAIT=4, PRESENT=5, ERROR=6.
- IDLE:
  - iStart or iContinuous -> ARM.
  - An iFrameStart in the same cycle is not consumed; ARM waits for the next one.
- ARM:
  - Watchdog cleared on entry.
  - iFrameStart -> CLEAR.
- CLEAR:
  - oBufRst=1 for exactly CLR_CYC cycles, then -> CAPTURE.
  - oCapEn=0 throughout.
- CAPTURE:
  - oCapEn=1.
  - iCropDone -> PRESENT. This takes priority over every other event in the same cycle.
  - Else iDVAL && iY > Y_LAST -> NORM_WAIT.
  - Else iFrameStart -> ERROR (incomplete frame).
- NORM_WAIT:
  - oCapEn=0.
  - iCropDone -> PRESENT.
  - iFrameStart -> ERROR.
- PRESENT:
  - oImgValid=1 and held until iImgAck is sampled high.
  - iCropDone, iFrameStart and iStart are ignored.
  - On ack: oImgValid->0, oFrameCnt+1 (wraps all-ones -> 0); then iContinuous ? ARM : IDLE.
- Watchdog:
  - Counts each cycle in ARM, CLEAR, CAPTURE and NORM_WAIT; holds in other states.
  - Reaching TIMEOUT_CYC-1 -> ERROR.
  - PRESENT has no timeout, so the consumer may stall indefinitely.
- ERROR:
  - oTimeout=1 (sticky); oCapEn=oBufRst=oImgValid=0.
  - iStart -> ARM and clears oTimeout. iContinuous alone does not exit ERROR.
- iStart is ignored in every state except IDLE and ERROR.
- Watchdog width is ceil(log2(TIMEOUT_CYC)); terminal compare is exact, with no wrap.
- oBusy=1 in states 1..5.

Decomposition:
- Package capture_pkg:
  - cap_state_t enum (3-bit, encodings above).
  - Default constants CAP_TIMEOUT_CYC, CAP_Y_LAST, IMG_PIXELS=784.
- One sub-module, cap_watchdog:
  - Loadable up-counter with clear, enable and terminal-count pulse, parameterised by TIMEOUT_CYC.
- FSM, clear counter and frame counter live in the top.

Test Plan:
- Single shot:
  - Stimulus: iStart, iFrameStart, then with iContinuous=0 raise iDVAL at iY=465, pulse iCropDone, assert iImgAck 10 cycles after oImgValid rises.
  - Required: oBufRst high exactly 2 cycles; oCapEn high from CLEAR exit to the row-465 pixel; oImgValid high for 10 cycles; oFrameCnt=1; final state IDLE.
- Continuous:
  - Stimulus: iContinuous=1, 3 frames acked.
  - Required: oFrameCnt=3; each ack returns to ARM (oState=1) with no iStart needed.
- Incomplete frame:
  - Stimulus: second iFrameStart in CAPTURE with no iCropDone.
  - Required: ERROR, oTimeout=1, oCapEn=0; a later iStart gives oState=1 and oTimeout=0.
- Watchdog:
  - Stimulus: TIMEOUT_CYC=100, no iFrameStart after iStart.
  - Required: ERROR 100 cycles after ARM entry, oTimeout=1.
- Simultaneous events:
  - Stimulus: iCropDone and iFrameStart in the same CAPTURE cycle; separately, iStart and iFrameStart in the same IDLE cycle.
  - Required: first case -> PRESENT; second case -> ARM, waiting for the next iFrameStart.
- Reset mid-operation:
  - Stimulus: iRST low during PRESENT with oFrameCnt=5.
  - Required: all outputs 0 immediately (asynchronous); state IDLE.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared types and default constants for the capture sequencer.
package capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_CLEAR     = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_NORM_WAIT = 3'd4,
    ST_PRESENT   = 3'd5,
    ST_ERROR     = 3'd6
  } cap_state_t;

  localparam int CAP_TIMEOUT_CYC = 2_000_000;
  localparam int CAP_Y_LAST      = 464;
  localparam int IMG_PIXELS      = 784;

  // Busy covers every state between arming and handing off the image.
  function automatic logic cap_is_busy(cap_state_t s);
    return (s != ST_IDLE) && (s != ST_ERROR);
  endfunction

endpackage

// File: rtl/cap_watchdog.sv
// Frame watchdog: up-counter with clear and enable, flags the terminal count.
module cap_watchdog
  import capture_pkg::*;
#(
  parameter int TIMEOUT_CYC = CAP_TIMEOUT_CYC
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [WD_W-1:0] count_reg;

  // Count enabled cycles; clear wins so a fresh arm always starts at zero.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST)
      count_reg <= '0;
    else if (clr)
      count_reg <= '0;
    else if (en)
      count_reg <= count_reg + WD_W'(1);
  end

  // Exact terminal compare; the FSM leaves the counting states on this pulse,
  // so the counter never runs past it.
  assign tc = en && (count_reg == WD_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/capture_seq_ctrl.sv
// Frame-level sequencer for the crop/downsample/normalize path.
module capture_seq_ctrl
  import capture_pkg::*;
#(
  parameter int TIMEOUT_CYC = CAP_TIMEOUT_CYC,
  parameter int CLR_CYC     = 2,
  parameter int Y_LAST      = CAP_Y_LAST,
  parameter int FCNT_W      = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iStart,
  input  logic              iContinuous,
  input  logic              iFrameStart,
  input  logic              iDVAL,
  input  logic [9:0]        iY,
  input  logic              iCropDone,
  input  logic              iImgAck,
  output logic              oBufRst,
  output logic              oCapEn,
  output logic              oImgValid,
  output logic              oBusy,
  output logic              oTimeout,
  output logic [FCNT_W-1:0] oFrameCnt,
  output logic [2:0]        oState
);

  cap_state_t state_reg;
  cap_state_t state_next;
  logic [3:0] clr_cnt_reg;
  logic       clr_done;
  logic       past_last_row;
  logic       wd_clr;
  logic       wd_en;
  logic       wd_tc;

  assign clr_done      = (clr_cnt_reg == 4'(CLR_CYC - 1));
  assign past_last_row = iDVAL && (iY > 10'(Y_LAST));

  // Watchdog runs only while a frame is being acquired, restarts on ARM entry.
  assign wd_en  = (state_reg == ST_ARM) || (state_reg == ST_CLEAR) ||
                  (state_reg == ST_CAPTURE) || (state_reg == ST_NORM_WAIT);
  assign wd_clr = (state_next == ST_ARM) && (state_reg != ST_ARM);

  cap_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .iCLK (iCLK),
    .iRST (iRST),
    .clr  (wd_clr),
    .en   (wd_en),
    .tc   (wd_tc)
  );

  // Next-state decode; crop completion outranks every other event.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:
        if (iStart || iContinuous) state_next = ST_ARM;
      ST_ARM:
        if (wd_tc)            state_next = ST_ERROR;
        else if (iFrameStart) state_next = ST_CLEAR;
      ST_CLEAR:
        if (wd_tc)         state_next = ST_ERROR;
        else if (clr_done) state_next = ST_CAPTURE;
      ST_CAPTURE:
        if (iCropDone)          state_next = ST_PRESENT;
        else if (wd_tc)         state_next = ST_ERROR;
        else if (past_last_row) state_next = ST_NORM_WAIT;
        else if (iFrameStart)   state_next = ST_ERROR;
      ST_NORM_WAIT:
        if (iCropDone)                 state_next = ST_PRESENT;
        else if (wd_tc || iFrameStart) state_next = ST_ERROR;
      ST_PRESENT:
        if (iImgAck) state_next = iContinuous ? ST_ARM : ST_IDLE;
      ST_ERROR:
        if (iStart) state_next = ST_ARM;
      default:
        state_next = ST_IDLE;
    endcase
  end

  // State, clear counter and outputs, all registered from the next state.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_reg   <= ST_IDLE;
      clr_cnt_reg <= '0;
      oBufRst     <= 1'b0;
      oCapEn      <= 1'b0;
      oImgValid   <= 1'b0;
      oBusy       <= 1'b0;
      oTimeout    <= 1'b0;
      oFrameCnt   <= '0;
      oState      <= 3'd0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= (state_reg == ST_CLEAR) ? clr_cnt_reg + 4'd1 : 4'd0;
      oBufRst     <= (state_next == ST_CLEAR);
      oCapEn      <= (state_next == ST_CAPTURE);
      oImgValid   <= (state_next == ST_PRESENT);
      oBusy       <= cap_is_busy(state_next);
      oTimeout    <= (state_next == ST_ERROR);
      oState      <= state_next;
      if ((state_reg == ST_PRESENT) && iImgAck)
        oFrameCnt <= oFrameCnt + FCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_capture_seq_ctrl.sv
// Directed testbench for capture_seq_ctrl.
module tb_capture_seq_ctrl;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iStart = 1'b0;
  logic        iContinuous = 1'b0;
  logic        iFrameStart = 1'b0;
  logic        iDVAL = 1'b0;
  logic [9:0]  iY = '0;
  logic        iCropDone = 1'b0;
  logic        iImgAck = 1'b0;
  logic        oBufRst;
  logic        oCapEn;
  logic        oImgValid;
  logic        oBusy;
  logic        oTimeout;
  logic [15:0] oFrameCnt;
  logic [2:0]  oState;

  int tests_run = 0;
  int tests_failed = 0;

  capture_seq_ctrl #(
    .TIMEOUT_CYC (100),
    .CLR_CYC     (2),
    .Y_LAST      (464),
    .FCNT_W      (16)
  ) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iStart      (iStart),
    .iContinuous (iContinuous),
    .iFrameStart (iFrameStart),
    .iDVAL       (iDVAL),
    .iY          (iY),
    .iCropDone   (iCropDone),
    .iImgAck     (iImgAck),
    .oBufRst     (oBufRst),
    .oCapEn      (oCapEn),
    .oImgValid   (oImgValid),
    .oBusy       (oBusy),
    .oTimeout    (oTimeout),
    .oFrameCnt   (oFrameCnt),
    .oState      (oState)
  );

  always #5 iCLK = ~iCLK;

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick;
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic do_reset;
    iStart = 0; iContinuous = 0; iFrameStart = 0; iDVAL = 0;
    iY = '0; iCropDone = 0; iImgAck = 0;
    iRST = 0;
    tick;
    tick;
    iRST = 1;
  endtask

  task automatic pulse_start;
    iStart = 1; tick; iStart = 0;
  endtask

  task automatic pulse_frame_start;
    iFrameStart = 1; tick; iFrameStart = 0;
  endtask

  // ARM -> CLEAR (2 cycles) -> CAPTURE -> crop done -> PRESENT
  task automatic frame_to_present;
    pulse_frame_start;
    tick;
    tick;
    iCropDone = 1; tick; iCropDone = 0;
  endtask

  task automatic pulse_ack;
    iImgAck = 1; tick; iImgAck = 0;
  endtask

  task automatic test_reset;
    iRST = 0;
    tick;
    tests_run++;
    if ({oBufRst, oCapEn, oImgValid, oBusy, oTimeout} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 00000", {oBufRst, oCapEn, oImgValid, oBusy, oTimeout});
    end
    tests_run++;
    if (oState !== 3'd0 || oFrameCnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got state=%0d cnt=%0d expected state=0 cnt=0", oState, oFrameCnt);
    end
    iRST = 1;
    tick;
    $display("[TB] test_reset done");
  endtask

  task automatic test_single_shot;
    int bufrst_cnt;
    int valid_cnt;
    logic capen_bad;
    do_reset;
    pulse_start;
    tests_run++;
    if (oState !== 3'd1) begin
      tests_failed++;
      $display("FAIL ss_arm: got state %0d expected 1", oState);
    end
    pulse_frame_start;
    bufrst_cnt = 0;
    capen_bad  = 0;
    for (int i = 0; i < 10 && oState !== 3'd3; i++) begin
      if (oBufRst) bufrst_cnt++;
      if (oCapEn) capen_bad = 1;
      tick;
    end
    tests_run++;
    if (bufrst_cnt != 2 || capen_bad) begin
      tests_failed++;
      $display("FAIL ss_clear: got bufrst_cycles=%0d capen_in_clear=%0b expected 2 and 0", bufrst_cnt, capen_bad);
    end
    tests_run++;
    if (oState !== 3'd3 || oCapEn !== 1'b1 || oBufRst !== 1'b0) begin
      tests_failed++;
      $display("FAIL ss_capture_entry: got state=%0d capen=%0b bufrst=%0b expected 3 1 0", oState, oCapEn, oBufRst);
    end
    capen_bad = 0;
    iDVAL = 1;
    for (int y = 460; y <= 464; y++) begin
      iY = 10'(y);
      tick;
      if (oCapEn !== 1'b1 || oState !== 3'd3) capen_bad = 1;
    end
    iY = 10'd465;
    tick;
    iDVAL = 0;
    tests_run++;
    if (capen_bad) begin
      tests_failed++;
      $display("FAIL ss_capen_hold: got capen dropped before row 465 expected held");
    end
    tests_run++;
    if (oState !== 3'd4 || oCapEn !== 1'b0) begin
      tests_failed++;
      $display("FAIL ss_norm_wait: got state=%0d capen=%0b expected 4 0", oState, oCapEn);
    end
    iCropDone = 1; tick; iCropDone = 0;
    tests_run++;
    if (oState !== 3'd5 || oImgValid !== 1'b1) begin
      tests_failed++;
      $display("FAIL ss_present: got state=%0d valid=%0b expected 5 1", oState, oImgValid);
    end
    valid_cnt = 0;
    for (int i = 0; i < 50 && oImgValid; i++) begin
      valid_cnt++;
      if (valid_cnt == 10) iImgAck = 1;
      tick;
      iImgAck = 0;
    end
    tests_run++;
    if (valid_cnt != 10) begin
      tests_failed++;
      $display("FAIL ss_valid_len: got %0d cycles expected 10", valid_cnt);
    end
    tests_run++;
    if (oFrameCnt !== 16'd1 || oState !== 3'd0 || oBusy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ss_done: got cnt=%0d state=%0d busy=%0b expected 1 0 0", oFrameCnt, oState, oBusy);
    end
    $display("[TB] test_single_shot done");
  endtask

  task automatic test_continuous;
    do_reset;
    iContinuous = 1;
    tick;
    tests_run++;
    if (oState !== 3'd1 || oBusy !== 1'b1) begin
      tests_failed++;
      $display("FAIL cont_autoarm: got state=%0d busy=%0b expected 1 1", oState, oBusy);
    end
    for (int f = 0; f < 3; f++) begin
      frame_to_present;
      tests_run++;
      if (oState !== 3'd5) begin
        tests_failed++;
        $display("FAIL cont_present_%0d: got state %0d expected 5", f, oState);
      end
      pulse_ack;
      tests_run++;
      if (oState !== 3'd1 || oImgValid !== 1'b0) begin
        tests_failed++;
        $display("FAIL cont_rearm_%0d: got state=%0d valid=%0b expected 1 0", f, oState, oImgValid);
      end
    end
    tests_run++;
    if (oFrameCnt !== 16'd3) begin
      tests_failed++;
      $display("FAIL cont_count: got %0d expected 3", oFrameCnt);
    end
    iContinuous = 0;
    $display("[TB] test_continuous done");
  endtask

  task automatic test_incomplete;
    do_reset;
    pulse_start;
    pulse_frame_start;
    tick;
    tick;
    tests_run++;
    if (oState !== 3'd3) begin
      tests_failed++;
      $display("FAIL inc_capture: got state %0d expected 3", oState);
    end
    pulse_frame_start;
    tests_run++;
    if (oState !== 3'd6 || oTimeout !== 1'b1 || oCapEn !== 1'b0 || oBusy !== 1'b0) begin
      tests_failed++;
      $display("FAIL inc_error: got state=%0d to=%0b capen=%0b busy=%0b expected 6 1 0 0", oState, oTimeout, oCapEn, oBusy);
    end
    iContinuous = 1;
    tick;
    iContinuous = 0;
    tests_run++;
    if (oState !== 3'd6 || oTimeout !== 1'b1) begin
      tests_failed++;
      $display("FAIL inc_cont_no_exit: got state=%0d to=%0b expected 6 1", oState, oTimeout);
    end
    pulse_start;
    tests_run++;
    if (oState !== 3'd1 || oTimeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL inc_restart: got state=%0d to=%0b expected 1 0", oState, oTimeout);
    end
    $display("[TB] test_incomplete done");
  endtask

  task automatic test_watchdog;
    int n;
    do_reset;
    pulse_start;
    n = 0;
    while (oState !== 3'd6 && n < 300) begin
      tick;
      n++;
    end
    tests_run++;
    if (n != 100) begin
      tests_failed++;
      $display("FAIL wd_latency: got %0d cycles expected 100", n);
    end
    tests_run++;
    if (oTimeout !== 1'b1 || oBusy !== 1'b0) begin
      tests_failed++;
      $display("FAIL wd_flags: got to=%0b busy=%0b expected 1 0", oTimeout, oBusy);
    end
    // A stalled consumer must never trip the watchdog.
    do_reset;
    pulse_start;
    frame_to_present;
    repeat (150) tick;
    tests_run++;
    if (oState !== 3'd5 || oTimeout !== 1'b0 || oImgValid !== 1'b1) begin
      tests_failed++;
      $display("FAIL wd_present_stall: got state=%0d to=%0b valid=%0b expected 5 0 1", oState, oTimeout, oImgValid);
    end
    $display("[TB] test_watchdog done");
  endtask

  task automatic test_simultaneous;
    do_reset;
    pulse_start;
    pulse_frame_start;
    tick;
    tick;
    iCropDone = 1; iFrameStart = 1;
    tick;
    iCropDone = 0; iFrameStart = 0;
    tests_run++;
    if (oState !== 3'd5 || oTimeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL sim_crop_vs_fs: got state=%0d to=%0b expected 5 0", oState, oTimeout);
    end
    do_reset;
    iStart = 1; iFrameStart = 1;
    tick;
    iStart = 0; iFrameStart = 0;
    tick;
    tick;
    tests_run++;
    if (oState !== 3'd1 || oBufRst !== 1'b0) begin
      tests_failed++;
      $display("FAIL sim_start_fs: got state=%0d bufrst=%0b expected 1 0", oState, oBufRst);
    end
    pulse_frame_start;
    tests_run++;
    if (oState !== 3'd2 || oBufRst !== 1'b1) begin
      tests_failed++;
      $display("FAIL sim_next_fs: got state=%0d bufrst=%0b expected 2 1", oState, oBufRst);
    end
    $display("[TB] test_simultaneous done");
  endtask

  task automatic test_reset_mid;
    do_reset;
    iContinuous = 1;
    tick;
    for (int f = 0; f < 5; f++) begin
      frame_to_present;
      pulse_ack;
    end
    frame_to_present;
    tests_run++;
    if (oState !== 3'd5 || oFrameCnt !== 16'd5) begin
      tests_failed++;
      $display("FAIL rst_setup: got state=%0d cnt=%0d expected 5 5", oState, oFrameCnt);
    end
    #2;
    iRST = 0;
    #1;
    tests_run++;
    if ({oBufRst, oCapEn, oImgValid, oBusy, oTimeout} !== 5'b0 || oFrameCnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL rst_async_outputs: got flags=%b cnt=%0d expected 00000 0", {oBufRst, oCapEn, oImgValid, oBusy, oTimeout}, oFrameCnt);
    end
    tests_run++;
    if (oState !== 3'd0) begin
      tests_failed++;
      $display("FAIL rst_async_state: got %0d expected 0", oState);
    end
    iContinuous = 0;
    @(negedge iCLK);
    iRST = 1;
    tick;
    tests_run++;
    if (oState !== 3'd0) begin
      tests_failed++;
      $display("FAIL rst_release_idle: got %0d expected 0", oState);
    end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    @(negedge iCLK);
    test_reset;
    test_single_shot;
    test_continuous;
    test_incomplete;
    test_watchdog;
    test_simultaneous;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
